dir_queue: RTL and testbench
============================

# dir_queue

Direction command buffer between `key_control` and `snake_field`. It accepts direction key presses at any rate and filters out no-op and reversing moves. It queues up to DEPTH pending turns and releases exactly one per game step, so that quick key sequences (e.g. up-then-left within one tick) are all executed instead of overwritten. Its `snake_dir` output drives `snake_field.snake_dir` directly.

## Interface
- `DEPTH`, 4: number of queued pending directions; power of two, ≥2.
- `INIT_DIR`, 2'd1 (right): direction after reset and after `start`.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: game-start pulse from `key_control`; clears the queue.
- `dir_in` in 2: requested direction. Encoding: 0 up, 1 right, 2 down, 3 left.
- `dir_valid` in 1: one-cycle pulse qualifying `dir_in` (key press).
- `step` in 1: game step pulse (`tick & is_running`); pops one entry.
- `snake_dir` out 2: committed direction consumed by `snake_field`.
- `count` out $clog2(DEPTH)+1: number of queued entries.
- `full` out 1: `count == DEPTH`.
- `drop` out 1: one-cycle pulse; the valid request was rejected.

## Operation
- Reset values: `snake_dir`=INIT_DIR, `count`=0, `full`=0, `drop`=0, all FIFO pointers 0.
- `start` has highest priority:
  - Queue cleared; `snake_dir`<=INIT_DIR; `drop`<=0.
  - `dir_valid` and `step` in the same cycle are ignored.
- Reference direction `ref`:
  - Tail entry if `count>0`, else `snake_dir`.
  - Always evaluated on the pre-edge state.
- Request rejected (`drop`=1) if any of:
  - `dir_in == ref` (no-op);
  - `dir_in == ref ^ 2'd2` (reversal);
  - queue full and no pop in the same cycle.
- Otherwise `dir_in` is written at the tail.
- `step` with `count>0`: head popped into `snake_dir`. `step` with `count==0`: `snake_dir` holds.
- Simultaneous push and pop:
  - Both occur; `count` unchanged.
  - When full, push is accepted because the pop frees a slot.
  - When empty, there is no bypass: the new entry is written and leaves on the next `step`.
  - `ref` for the push is still the pre-edge tail or `snake_dir`, not the popped value.
- Pointers wrap modulo DEPTH. `count` never exceeds DEPTH or goes below 0.
- `dir_valid` while `step` never arrives: entries accumulate up to DEPTH, and the excess is dropped.

## Timing
- All outputs are registered.
- `snake_dir` changes on the clock edge that samples `step`. `snake_field` sees the new direction from the next cycle; `snake_field` acts on the following `step`.
- `drop` asserts in the cycle after the offending `dir_valid`, for exactly one cycle.
- `count` and `full` reflect push/pop one cycle after the sampling edge.
- Asynchronous reset may occur mid-operation. All state returns to reset values immediately, and no partial entries survive.

## Configuration
- `DIR_QUEUE_FILTER_EN` defined: the no-op/reversal filter described above is active.
- Not defined:
  - Every valid request is queued; only the full rule causes `drop`.
  - `snake_field` then receives reversals unchanged.
  - This build is for debug only.

## Structure
- Shared package `snake_pkg`:
  - direction constants `DIR_UP`, `DIR_RIGHT`, `DIR_DOWN`, `DIR_LEFT`;
  - 2-bit direction typedef;
  - `dir_opposite` function (XOR 2).
- One sub-module, `dir_fifo`: a generic synchronous FIFO with `DEPTH`/`WIDTH` parameters and push, pop, head, tail and count.
- `dir_queue` holds `snake_dir`, the filter and the priority logic.

## Test plan
- Reset, then no activity → `snake_dir`=1, `count`=0, `drop`=0 for 100 cycles; three `step`s → `snake_dir` stays 1.
- `dir_valid` with 0 (up), then 3 (left) before any `step` → `count`=2; `step` → `snake_dir`=0; `step` → 3; `step` → stays 3.
- From `snake_dir`=1, `dir_valid` with 3 (reversal), then 1 (no-op) → two `drop` pulses, `count`=0. With the macro undefined → `count`=2, no `drop`.
- Fill with 0, 1, 0, 1 (DEPTH=4) → `full`=1; next valid 2 → `drop`. Valid 2 coincident with `step` → accepted, `count` stays 4, `snake_dir`=0.
- Queue holding 2 entries, `start` asserted together with `dir_valid` and `step` → `count`=0, `snake_dir`=1, no `drop`.
- Assert `rst` low mid-sequence with `count`=3 → outputs at reset values immediately. After release, first `step` leaves `snake_dir`=1.

Source files
------------

// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
//   Shared definitions for the snake game blocks.
//   - dir_t        : 2-bit direction (0 up, 1 right, 2 down, 3 left)
//   - DIR_*        : direction constants
//   - dir_opposite : returns the reverse direction (flip bit 1)
// -----------------------------------------------------------------------------
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_RIGHT = 2'd1;
    localparam dir_t DIR_DOWN  = 2'd2;
    localparam dir_t DIR_LEFT  = 2'd3;

    function automatic dir_t dir_opposite(input dir_t d);
        return d ^ 2'd2;
    endfunction

endpackage

// File: rtl/dir_queue_if.sv
// -----------------------------------------------------------------------------
// dir_queue_if
//   Command bus between key_control / snake_field and dir_queue.
//   master (key_control side): drives start, dir_in, dir_valid, step;
//                              observes snake_dir, count, full, drop.
//   slave  (dir_queue side)  : the reverse.
//   Parameter DEPTH sizes the count field ($clog2(DEPTH)+1 bits).
// -----------------------------------------------------------------------------
interface dir_queue_if #(
    parameter int unsigned DEPTH = 4
);
    import snake_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          start;
    dir_t          dir_in;
    logic          dir_valid;
    logic          step;
    dir_t          snake_dir;
    logic [CW-1:0] count;
    logic          full;
    logic          drop;

    modport master (
        output start, dir_in, dir_valid, step,
        input  snake_dir, count, full, drop
    );

    modport slave (
        input  start, dir_in, dir_valid, step,
        output snake_dir, count, full, drop
    );

endinterface

// File: rtl/dir_fifo.sv
// -----------------------------------------------------------------------------
// dir_fifo
//   Generic synchronous FIFO, asynchronous active-low reset.
//   Ports:
//     clk, rst      : clock, async active-low reset
//     clear         : synchronous flush (pointers and count to 0)
//     push, din     : write din at the tail (caller guarantees room)
//     pop           : remove head (caller guarantees non-empty)
//     head, tail    : oldest and newest stored entries
//     count, full   : registered occupancy and count==DEPTH flag
// -----------------------------------------------------------------------------
module dir_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [WIDTH-1:0]           tail,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    assign head = mem[rd_ptr];
    // Newest entry sits just behind the write pointer; wraps naturally.
    assign tail = mem[wr_ptr - AW'(1)];

endmodule

// File: rtl/dir_queue.sv
// -----------------------------------------------------------------------------
// dir_queue
//   Direction command buffer between key_control and snake_field. Queues up
//   to DEPTH turn requests and commits one per game step into snake_dir.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-low reset
//     bus  : dir_queue_if.slave (start, dir_in, dir_valid, step in;
//            snake_dir, count, full, drop out; all outputs registered)
//   Parameters: DEPTH (power of two, >=2), INIT_DIR (direction after
//   reset/start).
//   Build option: define DIR_QUEUE_FILTER_EN to reject no-op and reversing
//   requests; without it every request is queued and only a full queue
//   causes drop (debug build).
// -----------------------------------------------------------------------------
module dir_queue
    import snake_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter dir_t        INIT_DIR = DIR_RIGHT
) (
    input  logic       clk,
    input  logic       rst,
    dir_queue_if.slave bus
);

`ifdef DIR_QUEUE_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    dir_t          head;
    dir_t          tail;
    logic [CW-1:0] count;
    logic          full;
    dir_t          snake_dir_q;
    logic          drop_q;

    dir_t ref_dir;
    logic pop;
    logic push;
    logic reject_filter;
    logic reject_full;
    logic reject;

    always_comb begin
        // Reference is the last thing the snake will be heading, taken from
        // pre-edge state even when a pop happens in the same cycle.
        ref_dir       = (count != '0) ? tail : snake_dir_q;
        pop           = bus.step && (count != '0) && !bus.start;
        reject_filter = FILTER_ON &&
                        ((bus.dir_in == ref_dir) ||
                         (bus.dir_in == dir_opposite(ref_dir)));
        // A same-cycle pop frees a slot, so a full queue still accepts.
        reject_full   = full && !pop;
        reject        = reject_filter || reject_full;
        push          = bus.dir_valid && !bus.start && !reject;
    end

    dir_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.start),
        .push  (push),
        .din   (bus.dir_in),
        .pop   (pop),
        .head  (head),
        .tail  (tail),
        .count (count),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snake_dir_q <= INIT_DIR;
            drop_q      <= 1'b0;
        end else if (bus.start) begin
            snake_dir_q <= INIT_DIR;
            drop_q      <= 1'b0;
        end else begin
            if (pop) begin
                snake_dir_q <= head;
            end
            drop_q <= bus.dir_valid && reject;
        end
    end

    assign bus.snake_dir = snake_dir_q;
    assign bus.count     = count;
    assign bus.full      = full;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_dir_queue.sv
// -----------------------------------------------------------------------------
// tb_dir_queue
//   Directed, table-driven bench for dir_queue (DEPTH=4, INIT_DIR=right).
//   Expectations for the filter rows follow DIR_QUEUE_FILTER_EN.
// -----------------------------------------------------------------------------
module tb_dir_queue;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    dir_queue_if #(.DEPTH(4)) bus ();

    dir_queue #(
        .DEPTH    (4),
        .INIT_DIR (2'd1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       start;
        logic       valid;
        logic [1:0] din;
        logic       step;
        logic [1:0] sd;
        int         cnt;
        logic       full;
        logic       drop;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic st, input logic v, input logic [1:0] d,
                                input logic s, input logic [1:0] sd, input int c,
                                input logic f, input logic dr);
        vec_t r;
        r.start = st; r.valid = v; r.din = d; r.step = s;
        r.sd = sd; r.cnt = c; r.full = f; r.drop = dr;
        return r;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] sd, input int c,
                             input logic f, input logic dr);
        check({tag, " snake_dir"}, int'(bus.snake_dir), int'(sd));
        check({tag, " count"},     int'(bus.count),     c);
        check({tag, " full"},      int'(bus.full),      int'(f));
        check({tag, " drop"},      int'(bus.drop),      int'(dr));
    endtask

    task automatic drive(input logic st, input logic v, input logic [1:0] d, input logic s);
        @(negedge clk);
        bus.start     = st;
        bus.dir_valid = v;
        bus.dir_in    = d;
        bus.step      = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        @(negedge clk);
        bus.start = 1'b0; bus.dir_valid = 1'b0; bus.dir_in = 2'd0; bus.step = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.dir_valid = 1'b0; bus.dir_in = 2'd0; bus.step = 1'b0;

        // Up-then-left before any step, then drain.
        vecs.push_back(mk(0, 1, 2'd0, 0, 2'd1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'd3, 0, 2'd1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'd0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'd3, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'd3, 0, 0, 0));
        // Back to right, then reversal and no-op requests.
        vecs.push_back(mk(1, 0, 2'd0, 0, 2'd1, 0, 0, 0));
`ifdef DIR_QUEUE_FILTER_EN
        vecs.push_back(mk(0, 1, 2'd3, 0, 2'd1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 2'd1, 0, 2'd1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 2'd0, 0, 2'd1, 0, 0, 0));
`else
        vecs.push_back(mk(0, 1, 2'd3, 0, 2'd1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'd1, 0, 2'd1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 2'd0, 0, 2'd1, 2, 0, 0));
`endif
        vecs.push_back(mk(1, 0, 2'd0, 0, 2'd1, 0, 0, 0));
        // Fill 0,1,0,1, overflow drop, then push+pop while full.
        vecs.push_back(mk(0, 1, 2'd0, 0, 2'd1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'd1, 0, 2'd1, 2, 0, 0));
        vecs.push_back(mk(0, 1, 2'd0, 0, 2'd1, 3, 0, 0));
        vecs.push_back(mk(0, 1, 2'd1, 0, 2'd1, 4, 1, 0));
        vecs.push_back(mk(0, 1, 2'd2, 0, 2'd1, 4, 1, 1));
        vecs.push_back(mk(0, 1, 2'd2, 1, 2'd0, 4, 1, 0));
        // Two entries, then start overrides valid and step.
        vecs.push_back(mk(1, 0, 2'd0, 0, 2'd1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd0, 0, 2'd1, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'd3, 0, 2'd1, 2, 0, 0));
        vecs.push_back(mk(1, 1, 2'd2, 1, 2'd1, 0, 0, 0));
        // Push+pop on empty: no bypass.
        vecs.push_back(mk(0, 1, 2'd2, 1, 2'd1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'd0, 1, 2'd2, 0, 0, 0));

        // Reset state, idle for 100 cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("in_reset", 2'd1, 0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            check_all($sformatf("idle%0d", i), 2'd1, 0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 2'd0, 1);
            check_all($sformatf("empty_step%0d", i), 2'd1, 0, 1'b0, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].valid, vecs[i].din, vecs[i].step);
            check_all($sformatf("row%0d", i), vecs[i].sd, vecs[i].cnt,
                      vecs[i].full, vecs[i].drop);
        end

        // Mid-sequence asynchronous reset with three entries queued.
        drive(1, 0, 2'd0, 0);
        drive(0, 1, 2'd0, 0);
        drive(0, 1, 2'd3, 0);
        drive(0, 1, 2'd0, 0);
        check_all("pre_rst", 2'd1, 3, 1'b0, 1'b0);
        idle_inputs();
        #2;
        rst = 1'b0;
        #1;
        check_all("async_rst", 2'd1, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 2'd0, 1);
        check_all("post_rst_step", 2'd1, 0, 1'b0, 1'b0);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
